// File: rtl/branch_predict_unit_if.sv
// Pipeline-facing bundle of the branch predictor: ID prediction, EX resolution,
// redirect/flush outputs and statistics.
interface branch_predict_unit_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic             id_is_branch;
    logic [31:0]      id_pc;
    logic [31:0]      id_target;
    logic             id_pred_taken;
    logic             id_redirect;
    logic             ex_valid;
    logic             ex_is_branch;
    logic [31:0]      ex_pc;
    logic [31:0]      ex_target;
    logic             ex_taken;
    logic             ex_pred_taken;
    logic             ex_stall;
    logic             npc_change;
    logic [31:0]      npc;
    logic [0:3]       flushes;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    // Pipeline side: drives the ID/EX information, consumes redirects.
    modport master (
        output id_valid, id_is_branch, id_pc, id_target,
        output ex_valid, ex_is_branch, ex_pc, ex_target, ex_taken, ex_pred_taken, ex_stall,
        input  id_pred_taken, id_redirect, npc_change, npc, flushes, branch_cnt, mispred_cnt
    );

    // Predictor side.
    modport slave (
        input  id_valid, id_is_branch, id_pc, id_target,
        input  ex_valid, ex_is_branch, ex_pc, ex_target, ex_taken, ex_pred_taken, ex_stall,
        output id_pred_taken, id_redirect, npc_change, npc, flushes, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predict_unit.sv
// 2-bit saturating-counter branch predictor: predicts in ID, resolves in EX,
// produces redirect PC and flush requests, and keeps saturating statistics.
module branch_predict_unit #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    branch_predict_unit_if.slave bus
);
    localparam int ENTRIES = 2 ** IDX_W;

    logic [1:0]       table_r [ENTRIES];
    logic [CNT_W-1:0] branch_cnt_r;
    logic [CNT_W-1:0] mispred_cnt_r;

    logic [IDX_W-1:0] id_idx_s;
    logic [IDX_W-1:0] ex_idx_s;
    logic             pred_s;
    logic             res_s;
    logic             mis_s;
    logic [31:0]      ex_seq_s;
    logic             id_pred_taken_s;
    logic             id_redirect_s;
    logic             npc_change_s;
    logic [31:0]      npc_s;
    logic [0:3]       flushes_s;

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        logic [1:0] nxt;
        if (up) begin
            nxt = (cnt == 2'b11) ? 2'b11 : cnt + 2'd1;
        end else begin
            nxt = (cnt == 2'b00) ? 2'b00 : cnt - 2'd1;
        end
        return nxt;
    endfunction

    assign id_idx_s = bus.id_pc[IDX_W+1:2];
    assign ex_idx_s = bus.ex_pc[IDX_W+1:2];

    // Prediction lookup, EX resolution and redirect/flush selection.
    always_comb begin
        pred_s          = bus.id_valid && bus.id_is_branch && table_r[id_idx_s][1];
        res_s           = bus.ex_valid && bus.ex_is_branch && !bus.ex_stall;
        mis_s           = res_s && (bus.ex_taken != bus.ex_pred_taken);
        ex_seq_s        = bus.ex_pc + 32'd4;
        id_pred_taken_s = 1'b0;
        id_redirect_s   = 1'b0;
        npc_change_s    = 1'b0;
        npc_s           = 32'h0;
        flushes_s       = 4'b0000;
        if (RST) begin
            id_pred_taken_s = 1'b0;
        end else begin
            id_pred_taken_s = pred_s;
            npc_change_s    = mis_s;
            // A mispredict flushes the ID instruction, so its redirect is dropped.
            if (mis_s) begin
                id_redirect_s = 1'b0;
                npc_s         = bus.ex_taken ? bus.ex_target : ex_seq_s;
                flushes_s     = 4'b1100;
            end else if (pred_s) begin
                id_redirect_s = 1'b1;
                npc_s         = bus.id_target;
                flushes_s     = 4'b1000;
            end else begin
                id_redirect_s = 1'b0;
                npc_s         = ex_seq_s;
                flushes_s     = 4'b0000;
            end
        end
    end

    assign bus.id_pred_taken = id_pred_taken_s;
    assign bus.id_redirect   = id_redirect_s;
    assign bus.npc_change    = npc_change_s;
    assign bus.npc           = npc_s;
    assign bus.flushes       = flushes_s;
    assign bus.branch_cnt    = branch_cnt_r;
    assign bus.mispred_cnt   = mispred_cnt_r;

    // Counter table training and saturating statistics.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_r[i] <= 2'b01;
            end
            branch_cnt_r  <= {CNT_W{1'b0}};
            mispred_cnt_r <= {CNT_W{1'b0}};
        end else if (res_s) begin
            table_r[ex_idx_s] <= sat_step(table_r[ex_idx_s], bus.ex_taken);
            if (branch_cnt_r != {CNT_W{1'b1}}) begin
                branch_cnt_r <= branch_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                branch_cnt_r <= branch_cnt_r;
            end
            if (mis_s && (mispred_cnt_r != {CNT_W{1'b1}})) begin
                mispred_cnt_r <= mispred_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                mispred_cnt_r <= mispred_cnt_r;
            end
        end else begin
            branch_cnt_r  <= branch_cnt_r;
            mispred_cnt_r <= mispred_cnt_r;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed-vector bench for branch_predict_unit (IDX_W=4, CNT_W=4).
module tb_branch_predict_unit;
    logic CLK;
    logic RST;
    int   checks;
    int   fails;

    branch_predict_unit_if #(.CNT_W(4)) bus ();

    branch_predict_unit #(.IDX_W(4), .CNT_W(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] tgt);
        bus.id_valid     = v;
        bus.id_is_branch = v;
        bus.id_pc        = pc;
        bus.id_target    = tgt;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic taken, input logic pred, input logic stall);
        bus.ex_valid      = v;
        bus.ex_is_branch  = v;
        bus.ex_pc         = pc;
        bus.ex_target     = tgt;
        bus.ex_taken      = taken;
        bus.ex_pred_taken = pred;
        bus.ex_stall      = stall;
    endtask

    task automatic idle();
        set_id(1'b0, 32'h0, 32'h0);
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle();
        tick();
        tick();
        RST = 1'b0;
    endtask

    // One EX resolution at pc, then EX goes idle.
    task automatic resolve(input logic [31:0] pc, input logic taken, input logic pred);
        set_ex(1'b1, pc, 32'h0000_0800, taken, pred, 1'b0);
        tick();
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        set_id(1'b1, 32'h40, 32'h100);
        set_ex(1'b1, 32'h40, 32'h80, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (bus.npc_change !== 1'b0) begin fails++; $display("FAIL rst_npc_change: got %0b want 0", bus.npc_change); end
        checks++; if (bus.npc !== 32'h0) begin fails++; $display("FAIL rst_npc: got %h want 00000000", bus.npc); end
        checks++; if (bus.flushes !== 4'b0000) begin fails++; $display("FAIL rst_flushes: got %b want 0000", bus.flushes); end
        tick();
        tick();
        RST = 1'b0;
        idle();
        #1;
        checks++; if (bus.branch_cnt !== 4'd0) begin fails++; $display("FAIL rst_branch_cnt: got %0d want 0", bus.branch_cnt); end
        checks++; if (bus.mispred_cnt !== 4'd0) begin fails++; $display("FAIL rst_mispred_cnt: got %0d want 0", bus.mispred_cnt); end
        set_id(1'b1, 32'h5C, 32'h100);
        #1;
        checks++; if (bus.id_pred_taken !== 1'b0) begin fails++; $display("FAIL rst_pred: got %0b want 0", bus.id_pred_taken); end
        idle();
    endtask

    task automatic test_mispredict();
        do_reset();
        set_ex(1'b1, 32'h40, 32'h80, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (bus.npc_change !== 1'b1) begin fails++; $display("FAIL mis_npc_change: got %0b want 1", bus.npc_change); end
        checks++; if (bus.npc !== 32'h80) begin fails++; $display("FAIL mis_npc: got %h want 00000080", bus.npc); end
        checks++; if (bus.flushes !== 4'b1100) begin fails++; $display("FAIL mis_flushes: got %b want 1100", bus.flushes); end
        tick();
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.npc_change !== 1'b0) begin fails++; $display("FAIL mis_after_npc_change: got %0b want 0", bus.npc_change); end
        checks++; if (bus.mispred_cnt !== 4'd1) begin fails++; $display("FAIL mis_mispred_cnt: got %0d want 1", bus.mispred_cnt); end
        checks++; if (bus.branch_cnt !== 4'd1) begin fails++; $display("FAIL mis_branch_cnt: got %0d want 1", bus.branch_cnt); end
    endtask

    task automatic test_predict();
        // Entry 0 is now 10; EX idle at pc 0 so the fallback npc would be 4.
        set_id(1'b1, 32'h40, 32'h80);
        #1;
        checks++; if (bus.id_pred_taken !== 1'b1) begin fails++; $display("FAIL pred_taken: got %0b want 1", bus.id_pred_taken); end
        checks++; if (bus.id_redirect !== 1'b1) begin fails++; $display("FAIL pred_redirect: got %0b want 1", bus.id_redirect); end
        checks++; if (bus.npc !== 32'h80) begin fails++; $display("FAIL pred_npc: got %h want 00000080", bus.npc); end
        checks++; if (bus.flushes !== 4'b1000) begin fails++; $display("FAIL pred_flushes: got %b want 1000", bus.flushes); end
        set_id(1'b1, 32'h44, 32'h90);
        #1;
        checks++; if (bus.id_pred_taken !== 1'b0) begin fails++; $display("FAIL pred_other_idx: got %0b want 0", bus.id_pred_taken); end
        checks++; if (bus.flushes !== 4'b0000) begin fails++; $display("FAIL pred_other_flushes: got %b want 0000", bus.flushes); end
        checks++; if (bus.npc !== 32'h4) begin fails++; $display("FAIL pred_other_npc: got %h want 00000004", bus.npc); end
        set_id(1'b0, 32'h40, 32'h80);
        #1;
        checks++; if (bus.id_pred_taken !== 1'b0) begin fails++; $display("FAIL pred_invalid: got %0b want 0", bus.id_pred_taken); end
        idle();
    endtask

    task automatic test_saturate_high();
        do_reset();
        for (int i = 0; i < 4; i++) resolve(32'h48, 1'b1, 1'b1);
        set_id(1'b1, 32'h0000_1048, 32'h200);
        #1;
        checks++; if (bus.id_pred_taken !== 1'b1) begin fails++; $display("FAIL sat_alias_pred: got %0b want 1", bus.id_pred_taken); end
        resolve(32'h48, 1'b0, 1'b1);
        set_id(1'b1, 32'h48, 32'h200);
        #1;
        checks++; if (bus.id_pred_taken !== 1'b1) begin fails++; $display("FAIL sat_after_nt1: got %0b want 1", bus.id_pred_taken); end
        resolve(32'h48, 1'b0, 1'b1);
        #1;
        checks++; if (bus.id_pred_taken !== 1'b0) begin fails++; $display("FAIL sat_after_nt2: got %0b want 0", bus.id_pred_taken); end
        // Same-index read and write: ID sees the old 01.
        set_ex(1'b1, 32'h48, 32'h300, 1'b1, 1'b1, 1'b0);
        #1;
        checks++; if (bus.id_pred_taken !== 1'b0) begin fails++; $display("FAIL hazard_pre: got %0b want 0", bus.id_pred_taken); end
        tick();
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.id_pred_taken !== 1'b1) begin fails++; $display("FAIL hazard_post: got %0b want 1", bus.id_pred_taken); end
        checks++; if (bus.branch_cnt !== 4'd7) begin fails++; $display("FAIL sat_branch_cnt: got %0d want 7", bus.branch_cnt); end
        checks++; if (bus.mispred_cnt !== 4'd2) begin fails++; $display("FAIL sat_mispred_cnt: got %0d want 2", bus.mispred_cnt); end
        idle();
    endtask

    task automatic test_saturate_low();
        do_reset();
        for (int i = 0; i < 3; i++) resolve(32'h4C, 1'b0, 1'b0);
        resolve(32'h4C, 1'b1, 1'b0);
        set_id(1'b1, 32'h4C, 32'h200);
        #1;
        checks++; if (bus.id_pred_taken !== 1'b0) begin fails++; $display("FAIL satlo_01: got %0b want 0", bus.id_pred_taken); end
        resolve(32'h4C, 1'b1, 1'b0);
        #1;
        checks++; if (bus.id_pred_taken !== 1'b1) begin fails++; $display("FAIL satlo_10: got %0b want 1", bus.id_pred_taken); end
        idle();
    endtask

    task automatic test_priority();
        do_reset();
        resolve(32'h40, 1'b1, 1'b1);
        set_id(1'b1, 32'h40, 32'h200);
        set_ex(1'b1, 32'h60, 32'h400, 1'b0, 1'b1, 1'b0);
        #1;
        checks++; if (bus.id_pred_taken !== 1'b1) begin fails++; $display("FAIL prio_pred: got %0b want 1", bus.id_pred_taken); end
        checks++; if (bus.id_redirect !== 1'b0) begin fails++; $display("FAIL prio_redirect: got %0b want 0", bus.id_redirect); end
        checks++; if (bus.npc_change !== 1'b1) begin fails++; $display("FAIL prio_npc_change: got %0b want 1", bus.npc_change); end
        checks++; if (bus.npc !== 32'h64) begin fails++; $display("FAIL prio_npc: got %h want 00000064", bus.npc); end
        checks++; if (bus.flushes !== 4'b1100) begin fails++; $display("FAIL prio_flushes: got %b want 1100", bus.flushes); end
        idle();
        set_ex(1'b1, 32'hFFFF_FFFC, 32'h400, 1'b0, 1'b1, 1'b0);
        #1;
        checks++; if (bus.npc !== 32'h0) begin fails++; $display("FAIL wrap_npc: got %h want 00000000", bus.npc); end
        idle();
    endtask

    task automatic test_stall();
        do_reset();
        set_ex(1'b1, 32'h70, 32'h300, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.npc_change !== 1'b0 || bus.flushes !== 4'b0000) begin fails++; $display("FAIL stall_%0d: npc_change %0b flushes %b want 0 0000", i, bus.npc_change, bus.flushes); end
            tick();
        end
        checks++; if (bus.branch_cnt !== 4'd0) begin fails++; $display("FAIL stall_branch_cnt: got %0d want 0", bus.branch_cnt); end
        set_id(1'b1, 32'h70, 32'h500);
        bus.ex_stall = 1'b0;
        #1;
        checks++; if (bus.id_pred_taken !== 1'b0) begin fails++; $display("FAIL stall_no_update: got %0b want 0", bus.id_pred_taken); end
        checks++; if (bus.npc_change !== 1'b1) begin fails++; $display("FAIL stall_release: got %0b want 1", bus.npc_change); end
        checks++; if (bus.npc !== 32'h300) begin fails++; $display("FAIL stall_npc: got %h want 00000300", bus.npc); end
        tick();
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.npc_change !== 1'b0) begin fails++; $display("FAIL stall_single_pulse: got %0b want 0", bus.npc_change); end
        checks++; if (bus.branch_cnt !== 4'd1) begin fails++; $display("FAIL stall_branch_cnt_after: got %0d want 1", bus.branch_cnt); end
        checks++; if (bus.id_pred_taken !== 1'b1) begin fails++; $display("FAIL stall_trained: got %0b want 1", bus.id_pred_taken); end
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_ex(1'b1, 32'h40, 32'h80, 1'b1, 1'b0, 1'b0);
        repeat (21) tick();
        checks++; if (bus.mispred_cnt !== 4'hF) begin fails++; $display("FAIL b2b_mispred_sat: got %h want f", bus.mispred_cnt); end
        checks++; if (bus.branch_cnt !== 4'hF) begin fails++; $display("FAIL b2b_branch_sat: got %h want f", bus.branch_cnt); end
        RST = 1'b1;
        set_id(1'b1, 32'h40, 32'h100);
        #1;
        checks++; if (bus.id_pred_taken !== 1'b0 || bus.id_redirect !== 1'b0) begin fails++; $display("FAIL b2b_rst_pred: pred %0b redirect %0b want 0 0", bus.id_pred_taken, bus.id_redirect); end
        checks++; if (bus.npc_change !== 1'b0 || bus.npc !== 32'h0) begin fails++; $display("FAIL b2b_rst_npc: npc_change %0b npc %h want 0 00000000", bus.npc_change, bus.npc); end
        tick();
        checks++; if (bus.mispred_cnt !== 4'd0 || bus.branch_cnt !== 4'd0) begin fails++; $display("FAIL b2b_rst_cnt: mis %0d br %0d want 0 0", bus.mispred_cnt, bus.branch_cnt); end
        RST = 1'b0;
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.id_pred_taken !== 1'b0) begin fails++; $display("FAIL b2b_table_cleared: got %0b want 0", bus.id_pred_taken); end
        resolve(32'h40, 1'b1, 1'b1);
        #1;
        checks++; if (bus.id_pred_taken !== 1'b1) begin fails++; $display("FAIL b2b_table_01: got %0b want 1", bus.id_pred_taken); end
        idle();
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        RST    = 1'b1;
        idle();
        test_reset();
        test_mispredict();
        test_predict();
        test_saturate_high();
        test_saturate_low();
        test_priority();
        test_stall();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
